// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end for the LSU ROM.
//   Walks a 16-bit PC, issues one ROM read per cycle while the prefetch FIFO
//   has room (counting the read in flight), captures the four ROM byte lanes
//   one cycle later as a little-endian 32-bit word, and queues {word, pc} for
//   the decoder. A redirect flushes the FIFO, drops any in-flight response
//   and reloads the PC.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   redirect, redirect_pc    flush + new PC (low two bits ignored)
//   rom_a, rom_re            ROM byte address / read enable
//   rom_q0..rom_q3           ROM bytes at a..a+3, one cycle after the read
//   out_valid/out_ready      decoder handshake on the FIFO head
//   out_instr, out_pc        head word and its address
//   out_fault                head word came from outside the ROM window
// Optional feature macro: FETCH_WINDOW_EN
//   When defined, fetch slots with pc < ROM_BASE do not touch the ROM; they
//   queue a zero word flagged with out_fault=1. When undefined, out_fault=0.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h8000,
  parameter logic [15:0] ROM_BASE = 16'h8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] rom_a,
  output logic        rom_re,
  input  logic [7:0]  rom_q0,
  input  logic [7:0]  rom_q1,
  input  logic [7:0]  rom_q2,
  input  logic [7:0]  rom_q3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [15:0] out_pc,
  output logic        out_fault
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [15:0]   pc, req_pc;
  logic          inflight;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   mem_instr [DEPTH];
  logic [15:0]   mem_pc    [DEPTH];
  logic          issue, push, pop;
  logic [31:0]   push_instr;
  logic [31:0]   rom_word;

  assign rom_word = {rom_q3, rom_q2, rom_q1, rom_q0};

  // The in-flight read reserves a FIFO slot so its response can never overflow.
  assign issue = !rst && !redirect && ((count + CW'(inflight)) < CW'(DEPTH));
  // A response landing in a redirect cycle belongs to the old stream.
  assign push  = inflight && !redirect;
  assign pop   = (count != '0) && out_ready && !redirect;

  assign rom_a     = pc;
  assign out_valid = (count != '0);
  assign out_instr = mem_instr[rd_ptr];
  assign out_pc    = mem_pc[rd_ptr];

`ifdef FETCH_WINDOW_EN
  logic in_window, req_fault;
  logic mem_fault [DEPTH];
  assign in_window  = (pc >= ROM_BASE);
  assign rom_re     = issue && in_window;
  assign push_instr = req_fault ? 32'h0000_0000 : rom_word;
  assign out_fault  = mem_fault[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_fault <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_fault[i] <= 1'b0;
    end else if (!redirect) begin
      if (issue) req_fault <= !in_window;
      if (push)  mem_fault[wr_ptr] <= req_fault;
    end
  end
`else
  assign rom_re     = issue;
  assign push_instr = rom_word;
  assign out_fault  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
      end
    end else if (redirect) begin
      pc       <= {redirect_pc[15:2], 2'b00};
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (issue) begin
        pc     <= pc + 16'd4;
        req_pc <= pc;
      end
      inflight <= issue;
      if (push) begin
        mem_instr[wr_ptr] <= push_instr;
        mem_pc[wr_ptr]    <= req_pc;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (count <= CW'(DEPTH)) && (pc[1:0] == 2'b00));
  a_base_aligned: assert property (@(posedge clk) ROM_BASE[1:0] == 2'b00);

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] rom_a;
  logic        rom_re;
  logic [7:0]  rom_q0 = '0, rom_q1 = '0, rom_q2 = '0, rom_q3 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [15:0] out_pc;
  logic        out_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'h8000), .ROM_BASE(16'h8000)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .rom_a(rom_a), .rom_re(rom_re),
    .rom_q0(rom_q0), .rom_q1(rom_q1), .rom_q2(rom_q2), .rom_q3(rom_q3),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_fault(out_fault)
  );

  function automatic logic [7:0] bv(input logic [15:0] x);
    return x[7:0] ^ x[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] word_at(input logic [15:0] a);
    return {bv(a + 16'd3), bv(a + 16'd2), bv(a + 16'd1), bv(a)};
  endfunction

  function automatic logic in_win(input logic [15:0] a);
`ifdef FETCH_WINDOW_EN
    return a >= 16'h8000;
`else
    return 1'b1;
`endif
  endfunction

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  function automatic ent_t mk(input logic [15:0] a);
    ent_t e;
    e.pc    = a;
    e.instr = in_win(a) ? word_at(a) : 32'h0;
    e.fault = !in_win(a);
    return e;
  endfunction

  // ROM: one-cycle read latency
  always @(posedge clk)
    if (rom_re) begin
      rom_q0 <= bv(rom_a);
      rom_q1 <= bv(rom_a + 16'd1);
      rom_q2 <= bv(rom_a + 16'd2);
      rom_q3 <= bv(rom_a + 16'd3);
    end

  // Scoreboard: exp_q models the FIFO contents; pend is the read awaiting data.
  ent_t        exp_q[$];
  logic        pend = 1'b0;
  logic [15:0] mpc = 16'h8000, ppc = '0;
  logic        e_issue, e_re;

  always @(negedge clk) begin
    #3;
    if (rst) begin
      exp_q.delete();
      pend = 1'b0;
      mpc  = 16'h8000;
      checks++;
      if (out_valid !== 1'b0 || rom_re !== 1'b0) begin
        errors++;
        $display("FAIL mon_reset: out_valid=%b rom_re=%b, want 0 0", out_valid, rom_re);
      end
    end else begin
      e_issue = !redirect && ((exp_q.size() + int'(pend)) < DEPTH);
      e_re    = e_issue && in_win(mpc);
      checks++;
      if (rom_re !== e_re) begin
        errors++;
        $display("FAIL mon_rom_re: got %b want %b (pc %h)", rom_re, e_re, mpc);
      end
      if (e_issue) begin
        checks++;
        if (rom_a !== mpc) begin
          errors++;
          $display("FAIL mon_rom_a: got %h want %h", rom_a, mpc);
        end
      end
      checks++;
      if (out_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL mon_valid: got %b want %b", out_valid, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        checks++;
        if ({out_pc, out_instr, out_fault} !== exp_q[0]) begin
          errors++;
          $display("FAIL mon_head: got pc=%h instr=%h f=%b want pc=%h instr=%h f=%b",
                   out_pc, out_instr, out_fault, exp_q[0].pc, exp_q[0].instr, exp_q[0].fault);
        end
      end
      if (redirect) begin
        exp_q.delete();
        pend = 1'b0;
        mpc  = {redirect_pc[15:2], 2'b00};
      end else begin
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (pend) exp_q.push_back(mk(ppc));
        pend = e_issue;
        if (e_issue) begin
          ppc = mpc;
          mpc = mpc + 16'd4;
        end
      end
    end
  end

  task automatic do_reset(input logic ready);
    @(negedge clk);
    rst = 1'b1; redirect = 1'b0; out_ready = ready;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0; redirect = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (rom_a !== 16'h8000) begin errors++; $display("FAIL rst_rom_a: got %h want 8000", rom_a); end
    checks++; if (rom_re !== 1'b0) begin errors++; $display("FAIL rst_rom_re: got %b want 0", rom_re); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", out_instr); end
    checks++; if (out_pc !== 16'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", out_pc); end
    checks++; if (out_fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b want 0", out_fault); end
  endtask

  task automatic test_stream();
    logic [15:0] a;
    do_reset(1'b1);
    for (int k = 0; k < 8; k++) begin
      #1;
      a = 16'h8000 + 16'(4 * k);
      checks++;
      if (rom_re !== 1'b1 || rom_a !== a) begin
        errors++; $display("FAIL stream_issue: re=%b a=%h want 1 %h", rom_re, rom_a, a);
      end
      if (k >= 2) begin
        a = 16'h8000 + 16'(4 * (k - 2));
        checks++;
        if (out_valid !== 1'b1 || out_pc !== a || out_instr !== word_at(a)) begin
          errors++;
          $display("FAIL stream_out: v=%b pc=%h instr=%h want 1 %h %h", out_valid, out_pc, out_instr, a, word_at(a));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int nre = 0;
    logic found = 1'b0;
    logic [15:0] first_a = '0;
    do_reset(1'b0);
    for (int k = 0; k < 8; k++) begin
      #1; if (rom_re === 1'b1) nre++;
      @(negedge clk);
    end
    #1;
    checks++; if (nre != DEPTH) begin errors++; $display("FAIL bp_reads: got %0d want %0d", nre, DEPTH); end
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 16'h8000 || rom_re !== 1'b0) begin
      errors++; $display("FAIL bp_hold: v=%b pc=%h re=%b want 1 8000 0", out_valid, out_pc, rom_re);
    end
    @(negedge clk);
    out_ready = 1'b1;
    for (int k = 0; k < 6 && !found; k++) begin
      #1;
      if (k == 1) begin
        checks++;
        if (out_pc !== 16'h8004) begin errors++; $display("FAIL bp_drain: pc=%h want 8004", out_pc); end
      end
      if (rom_re === 1'b1) begin found = 1'b1; first_a = rom_a; end
      @(negedge clk);
    end
    checks++;
    if (!found || first_a !== 16'h8010) begin
      errors++; $display("FAIL bp_restart: found=%b a=%h want 1 8010", found, first_a);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    repeat (4) @(negedge clk);
    redirect = 1'b1; redirect_pc = 16'h9C43; out_ready = 1'b1;
    #1;
    checks++;
    if (rom_re !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL redir_cycle: re=%b v=%b want 0 1", rom_re, out_valid);
    end
    @(negedge clk); redirect = 1'b0; #1;
    checks++;
    if (out_valid !== 1'b0 || rom_re !== 1'b1 || rom_a !== 16'h9C40) begin
      errors++; $display("FAIL redir_next: v=%b re=%b a=%h want 0 1 9c40", out_valid, rom_re, rom_a);
    end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_r2: v=%b want 0", out_valid); end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 16'h9C40 || out_instr !== word_at(16'h9C40)) begin
      errors++; $display("FAIL redir_r3: v=%b pc=%h instr=%h want 1 9c40 %h", out_valid, out_pc, out_instr, word_at(16'h9C40));
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [15:0] a;
    out_ready = 1'b1;
    @(negedge clk); redirect = 1'b1; redirect_pc = 16'hFFF8;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); redirect = 1'b0; #1;
      a = 16'hFFF8 + 16'(4 * k);
      checks++;
      if (rom_a !== a || rom_re !== in_win(a)) begin
        errors++; $display("FAIL wrap_issue: a=%h re=%b want %h %b", rom_a, rom_re, a, in_win(a));
      end
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 16'h0000 || out_fault !== !in_win(16'h0000)) begin
      errors++; $display("FAIL wrap_out: v=%b pc=%h f=%b want 1 0000 %b", out_valid, out_pc, out_fault, !in_win(16'h0000));
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_double_redirect();
    out_ready = 1'b1;
    @(negedge clk); redirect = 1'b1; redirect_pc = 16'h1000; #1;
    checks++; if (rom_re !== 1'b0) begin errors++; $display("FAIL dredir_1: re=%b want 0", rom_re); end
    @(negedge clk); redirect_pc = 16'h2006; #1;
    checks++; if (rom_re !== 1'b0) begin errors++; $display("FAIL dredir_2: re=%b want 0", rom_re); end
    @(negedge clk); redirect = 1'b0; #1;
    checks++;
    if (rom_a !== 16'h2004 || rom_re !== in_win(16'h2004) || out_valid !== 1'b0) begin
      errors++; $display("FAIL dredir_3: a=%h re=%b v=%b want 2004 %b 0", rom_a, rom_re, out_valid, in_win(16'h2004));
    end
    repeat (4) @(negedge clk);
  endtask

`ifdef FETCH_WINDOW_EN
  task automatic test_window();
    out_ready = 1'b1;
    @(negedge clk); redirect = 1'b1; redirect_pc = 16'h7FFC;
    @(negedge clk); redirect = 1'b0; #1;
    checks++;
    if (rom_re !== 1'b0 || rom_a !== 16'h7FFC) begin errors++; $display("FAIL win_skip: re=%b a=%h want 0 7ffc", rom_re, rom_a); end
    @(negedge clk); #1;
    checks++;
    if (rom_re !== 1'b1 || rom_a !== 16'h8000) begin errors++; $display("FAIL win_issue: re=%b a=%h want 1 8000", rom_re, rom_a); end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 16'h7FFC || out_instr !== 32'h0 || out_fault !== 1'b1) begin
      errors++; $display("FAIL win_fault: v=%b pc=%h instr=%h f=%b want 1 7ffc 0 1", out_valid, out_pc, out_instr, out_fault);
    end
    @(negedge clk); #1;
    checks++;
    if (out_pc !== 16'h8000 || out_instr !== word_at(16'h8000) || out_fault !== 1'b0) begin
      errors++; $display("FAIL win_ok: pc=%h instr=%h f=%b want 8000 %h 0", out_pc, out_instr, out_fault, word_at(16'h8000));
    end
    repeat (3) @(negedge clk);
  endtask
`endif

  task automatic test_reset_midflight();
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || rom_re !== 1'b1) begin errors++; $display("FAIL mrst_pre: v=%b re=%b want 1 1", out_valid, rom_re); end
    #1; rst = 1'b1; #1;
    checks++;
    if (out_valid !== 1'b0 || rom_re !== 1'b0 || rom_a !== 16'h8000) begin
      errors++; $display("FAIL mrst_now: v=%b re=%b a=%h want 0 0 8000", out_valid, rom_re, rom_a);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0; out_ready = 1'b1; #1;
    checks++;
    if (rom_re !== 1'b1 || rom_a !== 16'h8000 || out_valid !== 1'b0) begin
      errors++; $display("FAIL mrst_rel: re=%b a=%h v=%b want 1 8000 0", rom_re, rom_a, out_valid);
    end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_stale: v=%b want 0", out_valid); end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 16'h8000) begin errors++; $display("FAIL mrst_first: v=%b pc=%h want 1 8000", out_valid, out_pc); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_double_redirect();
`ifdef FETCH_WINDOW_EN
    test_window();
`endif
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the LSU ROM.
- Walks a 16-bit PC and drives the ROM's address and read-enable.
- Captures the ROM's four byte lanes one cycle later and assembles them into 32-bit little-endian instruction words.
- Buffers the words in a small prefetch FIFO, which the decoder drains over a valid/ready handshake; a redirect input flushes the FIFO on branches.

Parameters:
- DEPTH, 4: prefetch FIFO entries; power of two, 2..16.
- RESET_PC, 16'h8000: PC loaded on reset; base of the ROM window.
- ROM_BASE, 16'h8000: lowest valid ROM address; used only by the optional feature.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- redirect  in  1  flush and reload PC this cycle.
- redirect_pc  in  16  new PC on redirect; bits [1:0] are forced to 0.
- rom_a  out  16  ROM byte address.
- rom_re  out  1  ROM read enable.
- rom_q0, rom_q1, rom_q2, rom_q3  in  8 each  ROM bytes at a, a+1, a+2, a+3, valid one cycle after the read.
- out_valid  out  1  FIFO head holds a word.
- out_ready  in  1  decoder accepts the head.
- out_instr  out  32  {rom_q3, rom_q2, rom_q1, rom_q0} of the head entry.
- out_pc  out  16  address of the head word.
- out_fault  out  1  head word came from outside the ROM window (optional feature).

Behaviour:
- Reset (asynchronous, immediate): pc=RESET_PC; FIFO empty; in-flight flag cleared; rom_re=0; rom_a=RESET_PC; out_valid=0; out_instr=0; out_pc=0; out_fault=0.
- A reset asserted mid-request drops the in-flight response; the first read after reset release is at RESET_PC.
- Issue rule: rom_re=1 in cycle N iff !rst && !redirect && (count + inflight) < DEPTH.
  - count and inflight are the registered values; a pop in cycle N does not enable issue in cycle N.
- rom_a = pc, combinationally from the register, every cycle; the value matters only when rom_re=1.
- On issue, at the edge ending cycle N:
  - pc <= pc + 4, wrapping modulo 2^16 (16'hFFFC -> 16'h0000).
  - inflight <= 1, and the issued PC is latched as req_pc.
- Response capture: in cycle N+1 the block samples rom_q0..q3 at the closing edge.
  - It pushes {bytes, req_pc} if inflight=1 and the request was not killed.
  - inflight then clears unless a new issue occurs in the same cycle (back-to-back issue allowed, one read per cycle).
- Pop: when out_valid && out_ready, the head advances at the edge. Push and pop in the same cycle leave count unchanged.
- Overflow is impossible by the issue rule; this is an assertion target: count <= DEPTH always.
- Redirect (cycle R):
  - FIFO cleared (count=0, out_valid=0 from R+1).
  - Any response arriving in R is discarded.
  - pc <= {redirect_pc[15:2], 2'b00}.
  - No issue in R; the first read at the new PC is in R+1; its word is visible (out_valid=1) in R+3.
  - A pop in cycle R is ignored: redirect wins over pop.
- Redirect asserted on consecutive cycles: the last one wins; nothing is issued until the cycle after the final redirect.
- out_instr, out_pc and out_fault reflect the head entry registers and hold steady while out_valid && !out_ready.
- Latency: reset release at edge E gives a read in the next cycle and out_valid=1 two edges after that read issues.
- Steady-state throughput with out_ready=1 is one word per cycle.

Optional Feature:
- Macro: FETCH_WINDOW_EN.
- Defined:
  - When pc < ROM_BASE, the issue slot still consumes a cycle, but rom_re stays 0.
  - The pushed entry carries out_instr=32'h00000000 and out_fault=1, tagged with that pc, one cycle later, exactly as a normal response.
  - pc still advances by 4.
- Undefined: no window check; out_fault is tied to 0; every issue asserts rom_re.

Test Plan:
- Reset, then release with out_ready=1 -> rom_a walks 8000, 8004, 8008 with rom_re=1 each cycle; out_pc follows 8000, 8004 ... two cycles behind; out_instr = {q3,q2,q1,q0}.
- out_ready=0 from reset -> exactly DEPTH=4 reads issued (8000..800C), then rom_re=0; out_valid=1 with out_pc=8000 holding. Raising out_ready drains 8000..800C in order, and issue restarts at 8010.
- Redirect to 16'h9C43 while 3 entries are queued and 1 read is in flight -> next cycle out_valid=0; the in-flight word is never output; the next read is at 9C40; out_pc=9C40 three cycles after the redirect.
- Redirect to 16'hFFF8 with out_ready=1 -> reads FFF8, FFFC, 0000, 0004; pc wraps without an X state. Without FETCH_WINDOW_EN, words at 0000 have out_fault=0.
- FETCH_WINDOW_EN with redirect to 16'h7FFC -> rom_re=0 that cycle; entry 7FFC has out_instr=0 and out_fault=1; entry 8000 has rom_re=1 and out_fault=0.
- Assert rst while a read is in flight with 2 entries queued -> out_valid=0 and rom_re=0 immediately; after release the first rom_a=8000, and no stale word appears.
